// File: rtl/conv_mem_host_if.sv
// Bus bundle between the CONV accelerator / image loader (master) and conv_mem_host (slave).
// Ports: loader stream (load_valid/load_data/load_ready), start handshake (ready/busy),
//        image read (iaddr/idata), layer access (cwr/crd/csel/caddr_*/cdata_*),
//        dump read (dump_req/dump_sel/dump_addr/dump_data), sticky status (done/err).
interface conv_mem_host_if #(
  parameter int DATA_W = 20,
  parameter int ADDR_W = 12
);
  logic              load_valid;
  logic [DATA_W-1:0] load_data;
  logic              load_ready;
  logic              ready;
  logic              busy;
  logic [ADDR_W-1:0] iaddr;
  logic [DATA_W-1:0] idata;
  logic              cwr;
  logic [ADDR_W-1:0] caddr_wr;
  logic [DATA_W-1:0] cdata_wr;
  logic              crd;
  logic [ADDR_W-1:0] caddr_rd;
  logic [DATA_W-1:0] cdata_rd;
  logic [2:0]        csel;
  logic              dump_req;
  logic [2:0]        dump_sel;
  logic [ADDR_W-1:0] dump_addr;
  logic [DATA_W-1:0] dump_data;
  logic              done;
  logic              err;

  modport master (
    output load_valid, load_data, busy, iaddr, cwr, caddr_wr, cdata_wr,
           crd, caddr_rd, csel, dump_req, dump_sel, dump_addr,
    input  load_ready, ready, idata, cdata_rd, dump_data, done, err
  );

  modport slave (
    input  load_valid, load_data, busy, iaddr, cwr, caddr_wr, cdata_wr,
           crd, caddr_rd, csel, dump_req, dump_sel, dump_addr,
    output load_ready, ready, idata, cdata_rd, dump_data, done, err
  );
endinterface

// File: rtl/conv_mem_host.sv
// Memory-side responder for CONV: image store, five layer banks, load/start/run/done sequencing.
// Latency: idata and cdata_rd are combinational reads; writes land on the clock edge; dump_data is 1 cycle.
// Backpressure: load_ready is high only while loading; the CONV side has no stall (fixed timing).
// Ports: clk, reset (async, active-high), bus (conv_mem_host_if.slave).
// Optional: define CONV_MEM_WRCHK_EN to flag a second write to an already-written layer word.
module conv_mem_host #(
  parameter int DATA_W    = 20,
  parameter int ADDR_W    = 12,
  parameter int IMG_WORDS = 4096,
  parameter int L1_WORDS  = 1024,
  parameter int L2_WORDS  = 2048
) (
  input  logic           clk,
  input  logic           reset,
  conv_mem_host_if.slave bus
);
  localparam int IMG_AW = $clog2(IMG_WORDS);
  localparam int L1_AW  = $clog2(L1_WORDS);
  localparam int L2_AW  = $clog2(L2_WORDS);
  localparam logic [IMG_AW-1:0] LAST_WORD = IMG_AW'(IMG_WORDS - 1);

  typedef enum logic [1:0] {S_LOAD, S_READY, S_RUN, S_DONE} state_t;

  state_t            state, state_nxt;
  logic              armed;      // low during the first cycle after reset release
  logic [IMG_AW-1:0] lcnt;
  logic              err_q;
  logic [DATA_W-1:0] dump_q;
  logic              load_rdy, rdy, dn, load_fire;
  logic              rd_ok, wr_ok, rd_bad, wr_bad, wr_dup;

  logic [DATA_W-1:0] image [IMG_WORDS];
  logic [DATA_W-1:0] l0k0  [IMG_WORDS];
  logic [DATA_W-1:0] l0k1  [IMG_WORDS];
  logic [DATA_W-1:0] l1k0  [L1_WORDS];
  logic [DATA_W-1:0] l1k1  [L1_WORDS];
  logic [DATA_W-1:0] l2    [L2_WORDS];

  // Depth per bank code; invalid codes report depth 0 so every address is out of range.
  function automatic logic [ADDR_W:0] bank_depth(input logic [2:0] sel);
    case (sel)
      3'd1, 3'd2: bank_depth = (ADDR_W+1)'(IMG_WORDS);
      3'd3, 3'd4: bank_depth = (ADDR_W+1)'(L1_WORDS);
      3'd5:       bank_depth = (ADDR_W+1)'(L2_WORDS);
      default:    bank_depth = '0;
    endcase
  endfunction

  function automatic logic in_range(input logic [2:0] sel, input logic [ADDR_W-1:0] addr);
    return {1'b0, addr} < bank_depth(sel);
  endfunction

  function automatic logic [DATA_W-1:0] bank_word(input logic [2:0] sel, input logic [ADDR_W-1:0] addr);
    logic [DATA_W-1:0] w;
    w = '0;
    if (in_range(sel, addr)) begin
      case (sel)
        3'd1:    w = l0k0[addr[IMG_AW-1:0]];
        3'd2:    w = l0k1[addr[IMG_AW-1:0]];
        3'd3:    w = l1k0[addr[L1_AW-1:0]];
        3'd4:    w = l1k1[addr[L1_AW-1:0]];
        3'd5:    w = l2[addr[L2_AW-1:0]];
        default: w = '0;
      endcase
    end
    return w;
  endfunction

  assign rd_ok  = bus.crd && in_range(bus.csel, bus.caddr_rd);
  assign wr_ok  = bus.cwr && in_range(bus.csel, bus.caddr_wr);
  assign rd_bad = bus.crd && !rd_ok;
  assign wr_bad = bus.cwr && !wr_ok;

  assign load_fire = bus.load_valid && load_rdy;

  // Asynchronous reads: CONV samples one edge after presenting the address.
  assign bus.idata    = image[bus.iaddr[IMG_AW-1:0]];
  assign bus.cdata_rd = rd_ok ? bank_word(bus.csel, bus.caddr_rd) : '0;

  // Memories are not reset so contents survive a mid-operation reset.
  always_ff @(posedge clk) begin
    if (load_fire) image[lcnt] <= bus.load_data;
    if (wr_ok) begin
      case (bus.csel)
        3'd1:    l0k0[bus.caddr_wr[IMG_AW-1:0]] <= bus.cdata_wr;
        3'd2:    l0k1[bus.caddr_wr[IMG_AW-1:0]] <= bus.cdata_wr;
        3'd3:    l1k0[bus.caddr_wr[L1_AW-1:0]]  <= bus.cdata_wr;
        3'd4:    l1k1[bus.caddr_wr[L1_AW-1:0]]  <= bus.cdata_wr;
        3'd5:    l2[bus.caddr_wr[L2_AW-1:0]]    <= bus.cdata_wr;
        default: ;
      endcase
    end
  end

`ifdef CONV_MEM_WRCHK_EN
  logic [IMG_WORDS-1:0] seen_l0k0, seen_l0k1;
  logic [L1_WORDS-1:0]  seen_l1k0, seen_l1k1;
  logic [L2_WORDS-1:0]  seen_l2;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      seen_l0k0 <= '0;
      seen_l0k1 <= '0;
      seen_l1k0 <= '0;
      seen_l1k1 <= '0;
      seen_l2   <= '0;
    end else if (wr_ok) begin
      case (bus.csel)
        3'd1:    seen_l0k0[bus.caddr_wr[IMG_AW-1:0]] <= 1'b1;
        3'd2:    seen_l0k1[bus.caddr_wr[IMG_AW-1:0]] <= 1'b1;
        3'd3:    seen_l1k0[bus.caddr_wr[L1_AW-1:0]]  <= 1'b1;
        3'd4:    seen_l1k1[bus.caddr_wr[L1_AW-1:0]]  <= 1'b1;
        3'd5:    seen_l2[bus.caddr_wr[L2_AW-1:0]]    <= 1'b1;
        default: ;
      endcase
    end
  end

  // The overwrite itself still happens; only the flag is raised.
  always_comb begin
    wr_dup = 1'b0;
    if (wr_ok) begin
      case (bus.csel)
        3'd1:    wr_dup = seen_l0k0[bus.caddr_wr[IMG_AW-1:0]];
        3'd2:    wr_dup = seen_l0k1[bus.caddr_wr[IMG_AW-1:0]];
        3'd3:    wr_dup = seen_l1k0[bus.caddr_wr[L1_AW-1:0]];
        3'd4:    wr_dup = seen_l1k1[bus.caddr_wr[L1_AW-1:0]];
        3'd5:    wr_dup = seen_l2[bus.caddr_wr[L2_AW-1:0]];
        default: wr_dup = 1'b0;
      endcase
    end
  end
`else
  assign wr_dup = 1'b0;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= S_LOAD;
      armed <= 1'b0;
    end else begin
      state <= state_nxt;
      armed <= 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      lcnt   <= '0;
      err_q  <= 1'b0;
      dump_q <= '0;
    end else begin
      if (load_fire) lcnt <= lcnt + 1'b1;
      if (rd_bad || wr_bad || wr_dup) err_q <= 1'b1;
      dump_q <= (bus.dump_req && state == S_DONE) ? bank_word(bus.dump_sel, bus.dump_addr) : '0;
    end
  end

  always_comb begin
    state_nxt = state;
    load_rdy  = 1'b0;
    rdy       = 1'b0;
    dn        = 1'b0;
    case (state)
      S_LOAD: begin
        load_rdy = armed;
        if (armed && bus.load_valid && lcnt == LAST_WORD) state_nxt = S_READY;
      end
      S_READY: begin
        rdy = 1'b1;
        if (bus.busy) state_nxt = S_RUN;
      end
      S_RUN: begin
        if (!bus.busy) state_nxt = S_DONE;
      end
      S_DONE: begin
        dn = 1'b1;
      end
      default: state_nxt = S_LOAD;
    endcase
  end

  assign bus.load_ready = load_rdy;
  assign bus.ready      = rdy;
  assign bus.done       = dn;
  assign bus.err        = err_q;
  assign bus.dump_data  = dump_q;
endmodule

// File: tb/tb_conv_mem_host.sv
// Self-checking bench for conv_mem_host: vector table, directed FSM sequences, randomized traffic vs model.
// Latency expectations: combinational reads checked before the edge, err/dump checked after it.
// Ports: drives the master side of conv_mem_host_if, clk and reset.
module tb_conv_mem_host;
`ifdef CONV_MEM_WRCHK_EN
  localparam bit WRCHK = 1'b1;
`else
  localparam bit WRCHK = 1'b0;
`endif

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  conv_mem_host_if #(.DATA_W(20), .ADDR_W(12)) bus ();
  conv_mem_host dut (.clk(clk), .reset(reset), .bus(bus));

  // Reference model: plain arrays indexed by bank code and word address.
  logic [19:0] m_img  [4096];
  logic [19:0] m_bank [1:5][4096];
  bit          m_wr   [1:5][4096];
  bit          m_err;
  int checks = 0;
  int failures = 0;

  typedef struct {
    bit          rst_first;
    bit          cwr;
    logic [11:0] waddr;
    logic [19:0] wdata;
    logic [2:0]  sel;
    bit          crd;
    logic [11:0] raddr;
    logic [19:0] exp_rd;
    bit          exp_err;
  } vec_t;
  vec_t vt [19];

  function automatic int depth(input logic [2:0] s);
    case (s)
      3'd1, 3'd2: return 4096;
      3'd3, 3'd4: return 1024;
      3'd5:       return 2048;
      default:    return 0;
    endcase
  endfunction

  function automatic bit legal(input logic [2:0] s, input logic [11:0] a);
    return int'(a) < depth(s);
  endfunction

  function automatic logic [11:0] pick(input logic [2:0] s);
    int a;
    a = $urandom_range(16, 31);
    if ($urandom_range(0, 7) == 0) a = depth(s) - 2;
    return 12'(a);
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus.load_valid = 1'b0; bus.load_data = '0; bus.busy = 1'b0; bus.iaddr = '0;
    bus.cwr = 1'b0; bus.caddr_wr = '0; bus.cdata_wr = '0; bus.crd = 1'b0;
    bus.caddr_rd = '0; bus.csel = '0; bus.dump_req = 1'b0; bus.dump_sel = '0; bus.dump_addr = '0;
  endtask

  task automatic do_reset();
    idle();
    reset = 1'b1;
    #2;
    check("rst_load_ready", bus.load_ready, 0);
    check("rst_ready", bus.ready, 0);
    check("rst_done", bus.done, 0);
    check("rst_err", bus.err, 0);
    check("rst_cdata_rd", bus.cdata_rd, 0);
    check("rst_dump_data", bus.dump_data, 0);
    m_err = 1'b0;
    for (int s = 1; s <= 5; s++)
      for (int a = 0; a < 4096; a++) m_wr[s][a] = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1 reset = 1'b0;
    #1 check("load_ready_before_first_edge", bus.load_ready, 0);
    tick();
    check("load_ready_after_release", bus.load_ready, 1);
  endtask

  task automatic load_image(input bit ramp, input bit gaps);
    int acc;
    int cyc;
    logic [19:0] d;
    acc = 0;
    cyc = 0;
    while (acc < 4096 && cyc < 20000) begin
      bus.load_valid = gaps ? ($urandom_range(0, 3) != 0) : 1'b1;
      d = ramp ? 20'(acc) : 20'($urandom);
      bus.load_data = d;
      #1;
      if (bus.load_ready !== 1'b1) break;
      if (acc == 100) check("ready_low_while_loading", bus.ready, 0);
      if (bus.load_valid) begin
        m_img[acc] = d;
        acc++;
      end
      tick();
      cyc++;
    end
    bus.load_valid = 1'b0;
    check("load_accepts", acc, 4096);
    check("load_ready_drop", bus.load_ready, 0);
    check("ready_after_load", bus.ready, 1);
  endtask

  task automatic check_idata(input int n);
    logic [11:0] a;
    for (int i = 0; i < n; i++) begin
      a = 12'($urandom_range(0, 4095));
      bus.iaddr = a;
      #1 check("idata_rand", bus.idata, m_img[a]);
    end
  endtask

  task automatic apply_vec(input int i);
    if (vt[i].rst_first) do_reset();
    bus.cwr = vt[i].cwr; bus.caddr_wr = vt[i].waddr; bus.cdata_wr = vt[i].wdata;
    bus.csel = vt[i].sel; bus.crd = vt[i].crd; bus.caddr_rd = vt[i].raddr;
    #1 check($sformatf("vec%0d_rd", i), bus.cdata_rd, vt[i].exp_rd);
    if (vt[i].cwr && legal(vt[i].sel, vt[i].waddr)) begin
      m_bank[vt[i].sel][vt[i].waddr] = vt[i].wdata;
      m_wr[vt[i].sel][vt[i].waddr] = 1'b1;
    end
    tick();
    idle();
    check($sformatf("vec%0d_err", i), bus.err, vt[i].exp_err);
    m_err = vt[i].exp_err;
  endtask

  task automatic model_write(input logic [2:0] s, input logic [11:0] a, input logic [19:0] d);
    if (m_wr[s][a]) m_err = m_err | WRCHK;
    m_bank[s][a] = d;
    m_wr[s][a] = 1'b1;
  endtask

  task automatic dump_check(input string name, input bit req, input logic [2:0] s,
                            input logic [11:0] a, input logic [19:0] exp);
    bus.dump_req = req; bus.dump_sel = s; bus.dump_addr = a;
    tick();
    bus.dump_req = 1'b0;
    check(name, bus.dump_data, exp);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [2:0]  s;
    logic [11:0] wa, ra;
    logic [19:0] wd, exp;
    bit          w, r;

    //            rst cwr waddr     wdata      sel   crd raddr     exp_rd     exp_err
    vt[0]  = '{0, 1, 12'd5,    20'h12345, 3'd3, 0, 12'd0,    20'h0,     0};
    vt[1]  = '{0, 0, 12'd0,    20'h0,     3'd3, 1, 12'd5,    20'h12345, 0};
    vt[2]  = '{0, 1, 12'd4095, 20'hFFFFF, 3'd1, 0, 12'd0,    20'h0,     0};
    vt[3]  = '{0, 0, 12'd0,    20'h0,     3'd1, 1, 12'd4095, 20'hFFFFF, 0};
    vt[4]  = '{0, 1, 12'd7,    20'h11111, 3'd5, 0, 12'd0,    20'h0,     0};
    vt[5]  = '{0, 1, 12'd7,    20'h22222, 3'd5, 1, 12'd7,    20'h11111, WRCHK};
    vt[6]  = '{0, 0, 12'd0,    20'h0,     3'd5, 1, 12'd7,    20'h22222, WRCHK};
    vt[7]  = '{0, 1, 12'd0,    20'h00C0C, 3'd3, 0, 12'd0,    20'h0,     WRCHK};
    vt[8]  = '{1, 1, 12'd1024, 20'h55555, 3'd3, 0, 12'd0,    20'h0,     1};
    vt[9]  = '{1, 0, 12'd0,    20'h0,     3'd3, 1, 12'd1024, 20'h0,     1};
    vt[10] = '{1, 1, 12'd5,    20'h77777, 3'd7, 0, 12'd0,    20'h0,     1};
    vt[11] = '{1, 0, 12'd0,    20'h0,     3'd0, 1, 12'd0,    20'h0,     1};
    vt[12] = '{1, 0, 12'd0,    20'h0,     3'd5, 1, 12'd2048, 20'h0,     1};
    vt[13] = '{1, 0, 12'd0,    20'h0,     3'd6, 1, 12'd1,    20'h0,     1};
    vt[14] = '{1, 0, 12'd5,    20'h0,     3'd7, 0, 12'd5,    20'h0,     0};
    vt[15] = '{0, 1, 12'd1023, 20'h0BEEF, 3'd4, 0, 12'd0,    20'h0,     0};
    vt[16] = '{0, 0, 12'd0,    20'h0,     3'd4, 1, 12'd1023, 20'h0BEEF, 0};
    vt[17] = '{0, 0, 12'd0,    20'h0,     3'd3, 1, 12'd5,    20'h12345, 0};
    vt[18] = '{0, 0, 12'd0,    20'h0,     3'd3, 1, 12'd0,    20'h00C0C, 0};

    // Reset, ramp load, image read.
    do_reset();
    load_image(1'b1, 1'b0);
    bus.iaddr = 12'd130;
    #1 check("idata_130", bus.idata, 130);
    check_idata(16);

    // Legal layer accesses in S_READY, including same-cycle write/read.
    for (int i = 0; i < 8; i++) apply_vec(i);

    // Prefill random windows, then randomized read/write traffic.
    for (int sb = 1; sb <= 5; sb++) begin
      for (int a = 16; a <= 32; a++) begin
        s = 3'(sb);
        wa = (a == 32) ? 12'(depth(s) - 2) : 12'(a);
        wd = 20'($urandom);
        bus.cwr = 1'b1; bus.csel = s; bus.caddr_wr = wa; bus.cdata_wr = wd;
        model_write(s, wa, wd);
        tick();
      end
    end
    idle();
    check("prefill_err", bus.err, m_err);

    for (int n = 0; n < 400; n++) begin
      s = 3'($urandom_range(1, 5));
      wa = pick(s); ra = pick(s);
      w = 1'($urandom_range(0, 1)); r = 1'($urandom_range(0, 1));
      wd = 20'($urandom);
      bus.csel = s; bus.cwr = w; bus.crd = r;
      bus.caddr_wr = wa; bus.caddr_rd = ra; bus.cdata_wr = wd;
      exp = r ? m_bank[s][ra] : 20'h0;
      #1 check("rand_rd", bus.cdata_rd, exp);
      if (w) model_write(s, wa, wd);
      tick();
      check("rand_err", bus.err, m_err);
    end
    idle();

    // Dump is blocked before S_DONE.
    dump_check("dump_not_done", 1'b1, 3'd3, 12'd5, 20'h0);

    // Start/run/done handshake.
    bus.busy = 1'b1;
    #1 check("ready_before_busy_edge", bus.ready, 1);
    tick();
    check("ready_fall", bus.ready, 0);
    tick(); tick();
    check("run_done_low", bus.done, 0);
    check_idata(4);
    bus.busy = 1'b0;
    #1 check("done_before_edge", bus.done, 0);
    tick();
    check("done_rise", bus.done, 1);
    bus.busy = 1'b1;
    tick();
    bus.busy = 1'b0;
    tick(); tick();
    check("done_sticky", bus.done, 1);

    // Dump port in S_DONE.
    bus.dump_req = 1'b1; bus.dump_sel = 3'd3; bus.dump_addr = 12'd5;
    #1 check("dump_latency", bus.dump_data, 0);
    tick();
    bus.dump_req = 1'b0;
    check("dump_l1k0_5", bus.dump_data, m_bank[3][5]);
    for (int n = 0; n < 30; n++) begin
      s = 3'($urandom_range(1, 5));
      wa = pick(s);
      dump_check("dump_rand", 1'b1, s, wa, m_bank[s][wa]);
    end
    dump_check("dump_no_req", 1'b0, 3'd3, 12'd5, 20'h0);
    dump_check("dump_bad_sel", 1'b1, 3'd6, 12'd0, 20'h0);
    dump_check("dump_bad_addr", 1'b1, 3'd3, 12'd2000, 20'h0);
    check("dump_no_err", bus.err, m_err);

    // Illegal accesses, one per reset, then retained contents.
    for (int i = 8; i < 19; i++) apply_vec(i);

    // Random-data load with gaps, then reset in S_RUN and reload.
    load_image(1'b0, 1'b1);
    check_idata(16);
    bus.busy = 1'b1;
    tick(); tick();
    check("run_ready_low", bus.ready, 0);
    do_reset();
    load_image(1'b1, 1'b0);
    bus.iaddr = 12'd4095;
    #1 check("idata_4095", bus.idata, 4095);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/conv_mem_host.md
# conv_mem_host

Memory-side responder for the CONV accelerator. Holds the 64x64 input image and the five layer banks (L0 k0/k1, L1 k0/k1, L2), streams the image in from a loader port, raises `ready` to start the accelerator, and serves its `iaddr`/`idata` and `crd`/`cwr`/`csel` accesses with the exact timing CONV expects. After CONV drops `busy`, it exposes the banks on a dump port for result checking.

## Interface
Parameters:
- `DATA_W`, 20, word width of the image and all banks.
- `ADDR_W`, 12, address width.
- `IMG_WORDS`, 4096, image depth; also the L0 bank depth.
- `L1_WORDS`, 1024, depth of each L1 bank.
- `L2_WORDS`, 2048, depth of the L2 bank.

Ports:
- `clk` in 1: single clock, rising edge.
- `reset` in 1: asynchronous, active-high.
- `load_valid` in 1: loader word valid.
- `load_data` in 20: image word, in raster order.
- `load_ready` out 1: loader word accepted on this edge.
- `ready` out 1: image loaded, CONV may start.
- `busy` in 1: CONV running.
- `iaddr` in 12: image read address.
- `idata` out 20: image read data.
- `cwr` in 1: layer write strobe.
- `caddr_wr` in 12: write address.
- `cdata_wr` in 20: write data.
- `crd` in 1: layer read strobe.
- `caddr_rd` in 12: read address.
- `cdata_rd` out 20: read data.
- `csel` in 3: bank select.
- `dump_req` in 1: dump read request.
- `dump_sel` in 3: dump bank select, same encoding as `csel`.
- `dump_addr` in 12: dump address.
- `dump_data` out 20: dump read data.
- `done` out 1: CONV finished; sticky.
- `err` out 1: illegal access seen; sticky.

## Operation
- Bank encoding (`csel`/`dump_sel`): 001 L0k0 (4096), 010 L0k1 (4096), 011 L1k0 (1024), 100 L1k1 (1024), 101 L2 (2048). Codes 000, 110 and 111 are invalid.
- FSM states:
  - `S_LOAD`: `load_ready`=1. Each accepted word is written to `image[lcnt]` and `lcnt` increments. Acceptance of word 4095 moves the FSM to `S_READY`.
  - `S_READY`: `ready`=1. When `busy`=1 is sampled, go to `S_RUN`.
  - `S_RUN`: when `busy`=0 is sampled, go to `S_DONE`.
  - `S_DONE`: `done`=1. The state is terminal until reset.
- Image read: `idata` = `image[iaddr]`, combinational (asynchronous read). It is valid in every state.
- Layer read: `cdata_rd` = `bank[csel][caddr_rd]`, combinational, when `crd`=1. It is 0 when `crd`=0, when `csel` is invalid, or when the address is at or above the bank depth.
- Layer write: on the rising edge with `cwr`=1, write `cdata_wr` to `bank[csel][caddr_wr]`. Writes are accepted in any state.
- Illegal access: `cwr` or `crd` high with an invalid `csel`, or with an address at or above the bank depth. The write is dropped, the read returns 0, and `err` is set.
- Same-cycle `cwr` and `crd` to the same word: the read returns the old value; the new value is visible from the next cycle.
- Dump port: `dump_data` is registered with 1-cycle latency. It returns the bank word when `dump_req`=1 in `S_DONE`, and 0 otherwise. An illegal dump address returns 0 and does not set `err`.
- Reset mid-operation: FSM returns to `S_LOAD`, `lcnt`=0, all flags are cleared. Memory contents are retained.

## Timing
- Reset values: `load_ready`=0, `ready`=0, `idata`=image contents (combinational), `cdata_rd`=0, `dump_data`=0, `done`=0, `err`=0.
- `load_ready` rises on the first clock edge after reset deassertion.
- `ready` is high from the cycle after the 4096th load is accepted. It falls on the cycle after `busy`=1 is sampled.
- `done` rises 1 cycle after `busy`=0 is sampled in `S_RUN`.
- CONV registers an address on edge k and samples the data on edge k+1. The asynchronous read meets this with zero added latency.

## Configuration
- `CONV_MEM_WRCHK_EN` defined: each layer word has a written bit, cleared by reset. A second write to an already-written word is still performed and sets `err`.
- Without the macro: overwrites are silent and no written bits are implemented.

## Test plan
- Load ramp `image[i]=i` with `load_valid` held high -> `load_ready` drops after exactly 4096 accepts; `ready`=1 on the next cycle; `idata` for `iaddr=12'd130` is 130.
- Raise `busy` while `ready`=1 -> `ready`=0 on the next cycle. Drop `busy` -> `done`=1 one cycle later and stays high.
- Write `cwr=1`, `csel=3'b011`, `caddr_wr=12'd5`, `cdata_wr=20'h12345`, then `crd=1` on the same address -> `cdata_rd`=20'h12345. Dump of bank 011 address 5 in `S_DONE` -> `dump_data`=20'h12345 one cycle after the request.
- Write to bank 011 at address 1024, then write with `csel=3'b111` -> writes dropped, `cdata_rd`=0 on read-back, `err`=1.
- With `CONV_MEM_WRCHK_EN` defined, write L2 address 7 twice -> `err`=1 and the second value is stored. Without the macro -> `err`=0.
- Assert `reset` in `S_RUN` -> `done`=0, `ready`=0, `load_ready`=1 after release. Reload 4096 words -> `ready`=1 again.
